// File: rtl/nn_pkg.sv
// Shared constants for the NN layer engine: FSM encoding, activation modes
// and signed saturation-limit helpers.
package nn_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_LOAD_IN = 3'd1;
    localparam state_t ST_MAC     = 3'd2;
    localparam state_t ST_WRITE   = 3'd3;
    localparam state_t ST_DONE    = 3'd4;

    // Mode 3 falls through to linear.
    localparam logic [1:0] ACT_STEP = 2'd0;
    localparam logic [1:0] ACT_RELU = 2'd1;
    localparam logic [1:0] ACT_LIN  = 2'd2;

    function automatic logic signed [63:0] smax(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] smin(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/nn_layer_engine_if.sv
// Avalon-MM master bundle used by the layer engine to reach input, weight
// and output memory.
interface nn_layer_engine_if #(
    parameter int DW = 16
);
    logic [31:0]   address;
    logic          read_n;
    logic          write_n;
    logic          chipselect;
    logic [1:0]    byteenable;
    logic [DW-1:0] writedata;
    logic [DW-1:0] readdata;
    logic          readdatavalid;
    logic          waitrequest;

    modport master (
        output address, read_n, write_n, chipselect, byteenable, writedata,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, read_n, write_n, chipselect, byteenable, writedata,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/nn_mac_unit.sv
// Saturating multiply-accumulate with bias and activation; the node result
// is combinational in the bias cycle and the accumulator clears on that edge.
module nn_mac_unit
    import nn_pkg::*;
#(
    parameter int DW    = 16,
    parameter int ACC_W = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clr_i,
    input  logic                 w_vld_i,
    input  logic                 b_vld_i,
    input  logic [1:0]           act_mode_i,
    input  logic signed [DW-1:0] din_i,
    input  logic signed [DW-1:0] x_i,
    output logic [DW-1:0]        res_o
);
    localparam logic signed [ACC_W-1:0] AMAX = ACC_W'(smax(ACC_W));
    localparam logic signed [ACC_W-1:0] AMIN = ACC_W'(smin(ACC_W));
    localparam logic signed [ACC_W-1:0] DMAX = ACC_W'(smax(DW));
    localparam logic signed [ACC_W-1:0] DMIN = ACC_W'(smin(DW));

    logic signed [ACC_W-1:0] acc_q, acc_d, sat;
    logic signed [2*DW-1:0]  prod;
    logic signed [ACC_W:0]   addend, sum;

    always_comb begin
        prod   = $signed({{DW{din_i[DW-1]}}, din_i}) * $signed({{DW{x_i[DW-1]}}, x_i});
        addend = b_vld_i ? {{(ACC_W + 1 - DW){din_i[DW-1]}}, din_i}
                         : {{(ACC_W + 1 - 2*DW){prod[2*DW-1]}}, prod};
        // One guard bit is enough to detect overflow of a single addition.
        sum    = {acc_q[ACC_W-1], acc_q} + addend;
        if (sum[ACC_W] != sum[ACC_W-1]) sat = sum[ACC_W] ? AMIN : AMAX;
        else                            sat = sum[ACC_W-1:0];

        res_o = '0;
        case (act_mode_i)
            ACT_STEP: res_o = {{(DW-1){1'b0}}, ~sat[ACC_W-1]};
            ACT_RELU: begin
                if (sat[ACC_W-1])   res_o = '0;
                else if (sat > DMAX) res_o = DMAX[DW-1:0];
                else                res_o = sat[DW-1:0];
            end
            default: begin
                if (sat > DMAX)      res_o = DMAX[DW-1:0];
                else if (sat < DMIN) res_o = DMIN[DW-1:0];
                else                 res_o = sat[DW-1:0];
            end
        endcase

        acc_d = acc_q;
        if (clr_i || b_vld_i) acc_d = '0;
        else if (w_vld_i)     acc_d = sat;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) acc_q <= '0;
        else          acc_q <= acc_d;
    end

endmodule

// File: rtl/nn_layer_engine.sv
// Fully-connected layer engine: fetches the input vector, streams weights and
// biases over Avalon-MM through the MAC unit, then writes back the results.
module nn_layer_engine
    import nn_pkg::*;
#(
    parameter int N_IN  = 784,
    parameter int N_OUT = 200,
    parameter int DW    = 16,
    parameter int ACC_W = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  act_mode,
    input  logic [31:0] in_base,
    input  logic [31:0] wt_base,
    input  logic [31:0] out_base,
    output logic        busy,
    output logic        done,
    nn_layer_engine_if.master av
);
    localparam int          IAW      = (N_IN  > 1) ? $clog2(N_IN)  : 1;
    localparam int          OAW      = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam logic [31:0] IN_TOT   = 32'(N_IN);
    localparam logic [31:0] MAC_TOT  = 32'(N_OUT * (N_IN + 1));
    localparam logic [31:0] OUT_TOT  = 32'(N_OUT);

    state_t      state_q, state_d;
    logic [1:0]  mode_q, mode_d;
    logic [31:0] wt_base_q, wt_base_d, out_base_q, out_base_d;
    logic [31:0] addr_q, addr_d;
    logic        read_n_q, read_n_d, write_n_q, write_n_d;
    logic [31:0] req_q, req_d, rsp_q, rsp_d, idx_q, idx_d, node_q, node_d, wr_q, wr_d;

    logic [DW-1:0]  in_buf  [2**IAW];
    logic [DW-1:0]  out_buf [2**OAW];
    logic [DW-1:0]  ib_rd_q, ob_rd_q, res;
    logic [IAW-1:0] ib_waddr, ib_raddr;
    logic [OAW-1:0] ob_waddr, ob_raddr;
    logic           ib_we, ob_we, mac_clr, w_vld, b_vld;
    logic           rd_acc, wr_acc, rsp_ok, is_bias;
    logic [31:0]    rd_tot;

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        wt_base_d  = wt_base_q;
        out_base_d = out_base_q;
        addr_d     = addr_q;
        read_n_d   = read_n_q;
        write_n_d  = write_n_q;
        req_d      = req_q;
        rsp_d      = rsp_q;
        idx_d      = idx_q;
        node_d     = node_q;
        wr_d       = wr_q;
        ib_we      = 1'b0;
        ob_we      = 1'b0;
        mac_clr    = 1'b0;
        w_vld      = 1'b0;
        b_vld      = 1'b0;

        rd_tot  = (state_q == ST_MAC) ? MAC_TOT : IN_TOT;
        rd_acc  = !read_n_q && !av.waitrequest;
        wr_acc  = !write_n_q && !av.waitrequest;
        rsp_ok  = av.readdatavalid && (rsp_q < rd_tot) &&
                  (state_q == ST_LOAD_IN || state_q == ST_MAC);
        is_bias = (idx_q == IN_TOT);

        // Weight rows are contiguous, so one linear read stream covers both phases.
        if (rd_acc) begin
            req_d = req_q + 32'd1;
            if (req_q == rd_tot - 32'd1) read_n_d = 1'b1;
            else                         addr_d   = addr_q + 32'd1;
        end

        case (state_q)
            ST_IDLE: if (start) begin
                state_d    = ST_LOAD_IN;
                mode_d     = act_mode;
                wt_base_d  = wt_base;
                out_base_d = out_base;
                addr_d     = in_base;
                read_n_d   = 1'b0;
                req_d      = '0;
                rsp_d      = '0;
                idx_d      = '0;
                node_d     = '0;
                wr_d       = '0;
                mac_clr    = 1'b1;
            end
            ST_LOAD_IN: if (rsp_ok) begin
                ib_we = 1'b1;
                rsp_d = rsp_q + 32'd1;
                if (rsp_q == IN_TOT - 32'd1) begin
                    state_d  = ST_MAC;
                    addr_d   = wt_base_q;
                    read_n_d = 1'b0;
                    req_d    = '0;
                    rsp_d    = '0;
                end
            end
            ST_MAC: if (rsp_ok) begin
                rsp_d = rsp_q + 32'd1;
                w_vld = !is_bias;
                b_vld = is_bias;
                idx_d = is_bias ? '0 : idx_q + 32'd1;
                if (is_bias) begin
                    ob_we  = 1'b1;
                    node_d = node_q + 32'd1;
                end
                if (rsp_q == MAC_TOT - 32'd1) begin
                    state_d   = ST_WRITE;
                    addr_d    = out_base_q;
                    write_n_d = 1'b0;
                end
            end
            ST_WRITE: if (wr_acc) begin
                wr_d = wr_q + 32'd1;
                if (wr_q == OUT_TOT - 32'd1) begin
                    write_n_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    addr_d = addr_q + 32'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // RAM read addresses look one step ahead so the registered read data is
    // ready when the matching weight response or write slot arrives.
    always_comb begin
        ib_waddr = rsp_q[IAW-1:0];
        ib_raddr = (idx_d == IN_TOT) ? '0 : idx_d[IAW-1:0];
        ob_waddr = node_q[OAW-1:0];
        ob_raddr = wr_d[OAW-1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            mode_q     <= '0;
            wt_base_q  <= '0;
            out_base_q <= '0;
            addr_q     <= '0;
            read_n_q   <= 1'b1;
            write_n_q  <= 1'b1;
            req_q      <= '0;
            rsp_q      <= '0;
            idx_q      <= '0;
            node_q     <= '0;
            wr_q       <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            wt_base_q  <= wt_base_d;
            out_base_q <= out_base_d;
            addr_q     <= addr_d;
            read_n_q   <= read_n_d;
            write_n_q  <= write_n_d;
            req_q      <= req_d;
            rsp_q      <= rsp_d;
            idx_q      <= idx_d;
            node_q     <= node_d;
            wr_q       <= wr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ib_we) in_buf[ib_waddr] <= av.readdata;
        ib_rd_q <= in_buf[ib_raddr];
    end

    always_ff @(posedge clk) begin
        if (ob_we) out_buf[ob_waddr] <= res;
    end

    // Bypass covers the last node landing in the slot about to be written first.
    always_ff @(posedge clk) begin
        if (!reset_n)                           ob_rd_q <= '0;
        else if (ob_we && ob_waddr == ob_raddr) ob_rd_q <= res;
        else                                    ob_rd_q <= out_buf[ob_raddr];
    end

    nn_mac_unit #(.DW(DW), .ACC_W(ACC_W)) u_mac (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr_i      (mac_clr),
        .w_vld_i    (w_vld),
        .b_vld_i    (b_vld),
        .act_mode_i (mode_q),
        .din_i      (av.readdata),
        .x_i        (ib_rd_q),
        .res_o      (res)
    );

    assign av.address    = addr_q;
    assign av.read_n     = read_n_q;
    assign av.write_n    = write_n_q;
    assign av.chipselect = !read_n_q || !write_n_q;
    assign av.byteenable = 2'b11;
    assign av.writedata  = ob_rd_q;
    assign busy          = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done          = (state_q == ST_DONE);

endmodule

// File: doc/nn_layer_engine.md
NN_LAYER_ENGINE -- requirements
Module: nn_layer_engine

Interface
REQ-001 SHALL provide parameter N_IN, 784, input vector length (1..4096).
REQ-002 SHALL provide parameter N_OUT, 200, output node count (1..1024).
REQ-003 SHALL provide parameter DW, 16, signed data/weight width.
REQ-004 SHALL provide parameter ACC_W, 32, signed accumulator width (>= 2*DW).
REQ-005 SHALL provide port clk  in  1  sole clock; reset is synchronous and active-low.
REQ-006 SHALL provide port reset_n  in  1  synchronous active-low reset.
REQ-007 SHALL provide ports start in 1 (pulse to launch) and act_mode in 2 (0 step, 1 ReLU, 2 linear; 3 treated as linear), sampled only on accepted start.
REQ-008 SHALL provide ports in_base, wt_base, out_base, each in 32, word addresses sampled on accepted start.
REQ-009 SHALL provide ports busy out 1 (high outside IDLE) and done out 1 (one-cycle pulse on completion).
REQ-010 SHALL provide Avalon-MM master: address out 32, read_n out 1, write_n out 1, chipselect out 1, byteenable out 2, writedata out DW, readdata in DW, readdatavalid in 1, waitrequest in 1.

Function
REQ-011 SHALL implement states IDLE, LOAD_IN, MAC, WRITE, DONE; IDLE->LOAD_IN on start; LOAD_IN->MAC after N_IN responses; MAC->WRITE after N_OUT*(N_IN+1) responses; WRITE->DONE after N_OUT accepted writes; DONE->IDLE next cycle.
REQ-012 SHALL ignore start when not in IDLE.
REQ-013 LOAD_IN SHALL issue reads at in_base+0..N_IN-1 and store responses, in arrival order, into an N_IN x DW buffer.
REQ-014 MAC SHALL read weight memory row-major: node k occupies wt_base+k*(N_IN+1)+0..N_IN-1 (weights), then +N_IN (bias).
REQ-015 A read or write SHALL be accepted only in a cycle with the request asserted and waitrequest low; address, read_n, write_n, writedata SHALL hold while waitrequest is high.
REQ-016 Reads SHALL be pipelined (one new request per accepted cycle); read_n SHALL deassert the cycle after the last request is accepted.
REQ-017 Per weight response, accumulator SHALL add sign-extended weight*input[i] (full 2*DW product); the bias response SHALL be added unscaled.
REQ-018 Accumulator SHALL saturate at ACC_W signed limits, never wrap.
REQ-019 After the bias, node result SHALL be: step: 1 if acc>=0 else 0; ReLU: 0 if acc<0 else min(acc, 2^(DW-1)-1); linear: acc clamped to [-2^(DW-1), 2^(DW-1)-1]; result stored in an N_OUT x DW buffer and acc cleared in the same cycle.
REQ-020 WRITE SHALL write results 0..N_OUT-1 to out_base+0..N_OUT-1, byteenable all ones.
REQ-021 readdatavalid outside LOAD_IN/MAC or beyond the expected response count SHALL be ignored.
REQ-022 chipselect SHALL be high only while read_n or write_n is low.
REQ-023 done SHALL pulse exactly one cycle in DONE; busy SHALL be low in that same cycle.

Reset
REQ-024 On reset_n low at a clk edge (including mid-transfer) state SHALL become IDLE and all counters/accumulator zero.
REQ-025 Reset values: read_n=1, write_n=1, chipselect=0, byteenable=2'b11, address=0, writedata=0, busy=0, done=0.
REQ-026 Buffer contents SHALL not require reset; outstanding bus responses after reset SHALL be ignored.

Structure
REQ-027 Package nn_pkg SHALL hold the state enum, the act_mode encoding and saturation-limit helper constants.
REQ-028 Multiply-accumulate-saturate-activate datapath SHALL be a sub-module nn_mac_unit (parameters DW, ACC_W).
REQ-029 Input and output buffers SHALL be inferable as single-clock RAMs.

Verification
REQ-030 N_IN=4, N_OUT=2, in={1,2,3,4}, weights {1,1,1,1,b=-10},{2,0,0,-1,b=0}, step -> out {1,0} (sums 0 and -2) at out_base, done one pulse.
REQ-031 Same data, ReLU -> out {0,0}; linear -> {0,-2} (16'hFFFE).
REQ-032 DW=16, N_IN=4, in all 32767, weights all 32767, linear -> out 32767; accumulator never wraps negative.
REQ-033 Random waitrequest (50%) and readdatavalid latency 1-8 cycles -> results identical to zero-wait run; address stable in every waitrequest-high cycle.
REQ-034 reset_n low for one cycle mid-MAC -> next cycle read_n=1, busy=0; new start then completes correctly despite stale readdatavalid pulses.
REQ-035 start pulsed during WRITE -> ignored; exactly N_OUT writes and one done pulse.
